// File: rtl/i2s_pkg.sv
// Shared I2S definitions: mode encodings and default geometry for the transmit path.
package i2s_pkg;

   typedef enum logic {
      I2S_MODE_STD = 1'b0,
      I2S_MODE_LJ  = 1'b1
   } i2s_mode_e;

   localparam int I2S_DEF_DATA_W   = 24;
   localparam int I2S_DEF_SLOT_W   = 32;
   localparam int I2S_DEF_BCLK_DIV = 4;

endpackage

// File: rtl/i2s_pair_fifo.sv
// Two-entry buffer of {left,right} sample pairs feeding the I2S serializer.
module i2s_pair_fifo #(
   parameter int WIDTH = 48
) (
   input  logic             clk_50,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             wr_fire;
   logic             rd_fire;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign rd_data = mem[rd_ptr];
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;

   // Storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk_50) begin
      if (wr_fire) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr_fire) wr_ptr <= ~wr_ptr;
         if (rd_fire) rd_ptr <= ~rd_ptr;
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S / left-justified stereo transmitter with a two-pair input buffer.
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int DATA_W   = I2S_DEF_DATA_W,
   parameter int SLOT_W   = I2S_DEF_SLOT_W,
   parameter int BCLK_DIV = I2S_DEF_BCLK_DIV
) (
   input  logic              clk_50,
   input  logic              reset,
   // Handshake: a pair transfers on a clk_50 edge where s_valid && s_ready;
   // the source holds s_valid and data stable until that edge.
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   input  logic              mode,
   output logic              bclk,
   output logic              daclrck,
   output logic              dacdat,
   output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       underrun_cnt
`endif
);

   localparam int FRAME_W = 2 * SLOT_W;
   localparam int DIV_W   = $clog2(BCLK_DIV);
   localparam int K_W     = $clog2(FRAME_W);

   logic [DIV_W-1:0]    div_cnt;
   logic                started;
   logic [K_W-1:0]      k;
   logic [K_W-1:0]      k_nxt;
   logic [FRAME_W-1:0]  frame_sr;
   logic [FRAME_W-1:0]  frame_load;
   logic [FRAME_W-1:0]  frame_nxt;
   i2s_mode_e           mode_q;
   i2s_mode_e           mode_nxt;
   logic                prev_lj;
   logic                lj_nxt;
   logic                div_wrap;
   logic                fall;
   logic                frame_start;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [2*DATA_W-1:0] head;

   assign s_ready  = !reset && !fifo_full;
   assign div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
   // The very first wrap after reset acts as a falling edge so frame 0 opens with bclk low.
   assign fall     = div_wrap && (bclk || !started);

   i2s_pair_fifo #(
      .WIDTH (2 * DATA_W)
   ) u_fifo (
      .clk_50  (clk_50),
      .reset   (reset),
      .wr_en   (s_valid && s_ready),
      .wr_data ({s_left, s_right}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      k_nxt = k;
      if (fall) begin
         if (!started || k == K_W'(FRAME_W - 1)) k_nxt = '0;
         else                                    k_nxt = k + 1'b1;
      end
      frame_start = fall && (k_nxt == '0);
      pop         = frame_start && !fifo_empty;
      frame_load  = '0;
      if (pop) begin
         frame_load[FRAME_W-1 -: DATA_W] = head[2*DATA_W-1 -: DATA_W];
         frame_load[SLOT_W-1 -: DATA_W]  = head[DATA_W-1:0];
      end
      // frame_sr MSB is always the left-justified bit of the period being driven.
      frame_nxt = frame_start ? frame_load : {frame_sr[FRAME_W-2:0], 1'b0};
      mode_nxt  = frame_start ? i2s_mode_e'(mode) : mode_q;
      lj_nxt    = frame_nxt[FRAME_W-1];
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         div_cnt  <= '0;
         started  <= 1'b0;
         k        <= '0;
         bclk     <= 1'b0;
         daclrck  <= 1'b1;
         dacdat   <= 1'b0;
         underrun <= 1'b0;
         frame_sr <= '0;
         mode_q   <= I2S_MODE_STD;
         prev_lj  <= 1'b0;
      end else begin
         div_cnt  <= div_wrap ? '0 : div_cnt + 1'b1;
         underrun <= frame_start && fifo_empty;
         if (div_wrap) begin
            started <= 1'b1;
            if (started) bclk <= ~bclk;
         end
         if (fall) begin
            k        <= k_nxt;
            frame_sr <= frame_nxt;
            mode_q   <= mode_nxt;
            prev_lj  <= lj_nxt;
            daclrck  <= (k_nxt >= K_W'(SLOT_W));
            // Standard I2S replays the previous period's left-justified bit.
            dacdat   <= (mode_nxt == I2S_MODE_LJ) ? lj_nxt : prev_lj;
         end
      end
   end

`ifdef I2S_TX_UNDERRUN_CNT_EN
   always_ff @(posedge clk_50) begin
      if (reset)                                         underrun_cnt <= '0;
      else if (frame_start && fifo_empty && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule
